// File: rtl/mips_core_pkg.sv
// Shared types for the mips_core pipeline: skid-slice state and counter width
// used by the elastic inter-stage register pr_elastic.
package mips_core_pkg;

  typedef enum logic [1:0] {SLICE_EMPTY, SLICE_BUSY, SLICE_FULL} skid_state_t;

  localparam int PR_ELASTIC_CNT_W = 32;

endpackage

// File: rtl/pr_skid_slice.sv
// One 2-entry skid slice: main feeds out_data, skid catches the word that
// arrives in the cycle downstream stalls, so in_ready comes from state alone.
module pr_skid_slice
  import mips_core_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  skid_state_t       state;
  logic [DATA_W-1:0] main;
  logic [DATA_W-1:0] skid;

  assign in_ready  = (state != SLICE_FULL);
  assign out_valid = (state != SLICE_EMPTY);
  assign out_data  = main;

  // in_valid is used directly as in_fire in EMPTY/BUSY since in_ready is 1
  // there; out_ready likewise stands for out_fire in BUSY/FULL.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state <= SLICE_EMPTY;
      main  <= '0;
      skid  <= '0;
    end else begin
      case (state)
        SLICE_EMPTY: begin
          if (in_valid) begin
            main  <= in_data;
            state <= SLICE_BUSY;
          end
        end
        SLICE_BUSY: begin
          if (in_valid && out_ready) begin
            main <= in_data;
          end else if (in_valid) begin
            skid  <= in_data;
            state <= SLICE_FULL;
          end else if (out_ready) begin
            state <= SLICE_EMPTY;
          end
        end
        SLICE_FULL: begin
          if (out_ready) begin
            main  <= skid;
            state <= SLICE_BUSY;
          end
        end
        default: state <= SLICE_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/pr_elastic.sv
// Elastic inter-stage register: DEPTH chained skid slices with valid/ready.
// Define PR_ELASTIC_PERF_EN to add the stall_cycles / occupancy counters.
module pr_elastic
  import mips_core_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PR_ELASTIC_PERF_EN
  ,
  output logic [PR_ELASTIC_CNT_W-1:0]   stall_cycles,
  output logic [$clog2(2*DEPTH+1)-1:0]  occupancy
`endif
);

  // Index k is the boundary in front of slice k; index DEPTH is the block output.
  logic [DATA_W-1:0] data_c [DEPTH+1];
  logic [DEPTH:0]    valid_c;
  logic [DEPTH:0]    ready_c;

  assign data_c[0]      = in_data;
  assign valid_c[0]     = in_valid;
  assign in_ready       = ready_c[0];
  assign ready_c[DEPTH] = out_ready;
  assign out_valid      = valid_c[DEPTH];
  assign out_data       = data_c[DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_slice
    pr_skid_slice #(
      .DATA_W (DATA_W)
    ) u_slice (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (valid_c[k]),
      .in_ready  (ready_c[k]),
      .in_data   (data_c[k]),
      .out_valid (valid_c[k+1]),
      .out_ready (ready_c[k+1]),
      .out_data  (data_c[k+1])
    );
  end

`ifdef PR_ELASTIC_PERF_EN
  localparam int OCC_W = $clog2(2*DEPTH+1);

  function automatic logic [PR_ELASTIC_CNT_W-1:0] sat_inc(
    input logic [PR_ELASTIC_CNT_W-1:0] v
  );
    return (v == {PR_ELASTIC_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // The stall count survives flush so a kill does not hide past backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (out_valid && !out_ready) begin
      stall_cycles <= sat_inc(stall_cycles);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      occupancy <= '0;
    end else begin
      occupancy <= occupancy + OCC_W'(in_fire) - OCC_W'(out_fire);
    end
  end
`endif

endmodule

// File: tb/tb_pr_elastic.sv
// Bench for pr_elastic: directed DEPTH=2 checks plus a randomized DEPTH=3 run
// against a queue model; perf counters are checked when PR_ELASTIC_PERF_EN is set.
module tb_pr_elastic;

  logic        clk;
  logic        rst_n;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data;
`ifdef PR_ELASTIC_PERF_EN
  logic [31:0] a_stall, b_stall;
  logic [2:0]  a_occ;
  logic [2:0]  b_occ;
`endif

  int vectors = 0;
  int miscompares = 0;

  pr_elastic #(.DATA_W(32), .DEPTH(2)) u_dut2 (
    .clk (clk), .rst_n (rst_n), .flush (a_flush),
    .in_valid (a_in_valid), .in_ready (a_in_ready), .in_data (a_in_data),
    .out_valid (a_out_valid), .out_ready (a_out_ready), .out_data (a_out_data)
`ifdef PR_ELASTIC_PERF_EN
    , .stall_cycles (a_stall), .occupancy (a_occ)
`endif
  );

  pr_elastic #(.DATA_W(32), .DEPTH(3)) u_dut3 (
    .clk (clk), .rst_n (rst_n), .flush (b_flush),
    .in_valid (b_in_valid), .in_ready (b_in_ready), .in_data (b_in_data),
    .out_valid (b_out_valid), .out_ready (b_out_ready), .out_data (b_out_data)
`ifdef PR_ELASTIC_PERF_EN
    , .stall_cycles (b_stall), .occupancy (b_occ)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] sb2[$];
  logic [31:0] sb3[$];

  initial begin
    int n, acc, outs, first_in, first_out, last_out, sent, recv, cyc;
    logic [31:0] exp_d, pod;
    logic pov, por;
`ifdef PR_ELASTIC_PERF_EN
    logic [31:0] s0;
`endif

    rst_n = 1'b0;
    a_flush = 0; a_in_valid = 1; a_in_data = 32'h55; a_out_ready = 0;
    b_flush = 0; b_in_valid = 1; b_in_data = 32'h66; b_out_ready = 0;

    // Reset held two cycles with in_valid high.
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_in_ready", a_in_ready, 1);
      chk("rst_out_data", a_out_data, 0);
      chk("rst_b_out_valid", b_out_valid, 0);
`ifdef PR_ELASTIC_PERF_EN
      chk("rst_stall", a_stall, 0);
      chk("rst_occ", a_occ, 0);
`endif
    end
    a_in_valid = 0; b_in_valid = 0; a_out_ready = 1;
    rst_n = 1'b1;
    outs = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (a_out_valid) outs++;
    end
    chk("rst_no_payload", outs, 0);

    // Streaming 1..8 with out_ready held high.
    a_out_ready = 1; outs = 0; first_in = -1; first_out = -1; last_out = -1;
    for (n = 0; n < 16; n++) begin
      a_in_valid = (n < 8);
      a_in_data  = n + 1;
      if (n < 8) chk("stream_in_ready", a_in_ready, 1);
      if (a_in_valid && a_in_ready) begin
        sb2.push_back(a_in_data);
        if (first_in < 0) first_in = n;
      end
      if (a_out_valid && a_out_ready) begin
        exp_d = sb2.pop_front();
        chk("stream_data", a_out_data, exp_d);
        if (first_out < 0) first_out = n;
        last_out = n;
        outs++;
      end
      step();
    end
    a_in_valid = 0;
    chk("stream_latency", first_out - first_in, 2);
    chk("stream_count", outs, 8);
    chk("stream_back_to_back", last_out - first_out, 7);

    // Backpressure: only the capacity of 4 may be accepted.
    a_out_ready = 0; acc = 0;
    for (n = 0; n < 8; n++) begin
      a_in_valid = 1;
      a_in_data  = 32'hA0 + acc;
      if (a_in_valid && a_in_ready) begin
        sb2.push_back(a_in_data);
        acc++;
      end
      step();
    end
    a_in_valid = 0;
    chk("bp_accepted", acc, 4);
    chk("bp_in_ready", a_in_ready, 0);
    chk("bp_out_valid", a_out_valid, 1);
    chk("bp_hold_data", a_out_data, 32'hA0);
    a_out_ready = 1; outs = 0;
    for (n = 0; n < 8; n++) begin
      if (a_out_valid && a_out_ready) begin
        chk("bp_drain_held", sb2.size() > 0, 1);
        exp_d = (sb2.size() > 0) ? sb2.pop_front() : 32'hX;
        chk("bp_drain_data", a_out_data, exp_d);
        outs++;
      end
      step();
    end
    chk("bp_drain_count", outs, 4);

    // Fill to FULL, then flush with a live input word.
    a_out_ready = 0; acc = 0; n = 0;
    while (a_in_ready && n < 20) begin
      a_in_valid = 1; a_in_data = 32'hB0 + acc;
      acc++;
      step();
      n++;
    end
    chk("fill_accepted", acc, 4);
`ifdef PR_ELASTIC_PERF_EN
    chk("perf_occ_full", a_occ, 4);
    s0 = a_stall;
    a_in_valid = 0;
    for (int i = 0; i < 5; i++) step();
    chk("perf_stall_plus5", a_stall, s0 + 5);
    chk("perf_occ_hold", a_occ, 4);
    s0 = a_stall;
`endif
    a_flush = 1; a_in_valid = 1; a_in_data = 32'hDEAD;
`ifdef PR_ELASTIC_PERF_EN
    a_out_ready = 1;
`endif
    step();
    a_flush = 0; a_in_valid = 0; a_out_ready = 1;
    sb2.delete();
    chk("flush_out_valid", a_out_valid, 0);
    chk("flush_in_ready", a_in_ready, 1);
    chk("flush_out_data", a_out_data, 0);
`ifdef PR_ELASTIC_PERF_EN
    chk("perf_occ_flush", a_occ, 0);
    chk("perf_stall_kept", a_stall, s0);
`endif
    outs = 0;
    for (int i = 0; i < 6; i++) begin
      if (a_out_valid) outs++;
      step();
    end
    chk("flush_nothing_emerges", outs, 0);

    // Randomized valid/ready on DEPTH=3 against the queue model.
    sent = 0; recv = 0; cyc = 0; pov = 0; por = 0; pod = '0;
    while (recv < 10000 && cyc < 60000) begin
      b_in_valid  = (sent < 10000) && ($urandom_range(0, 1) == 1);
      b_in_data   = $urandom;
      b_out_ready = ($urandom_range(0, 1) == 1);
      if (pov && !por) begin
        chk("rnd_stall_valid", b_out_valid, 1);
        chk("rnd_stall_data", b_out_data, pod);
      end
`ifdef PR_ELASTIC_PERF_EN
      chk("rnd_occ", b_occ, sb3.size());
`endif
      if (b_in_valid && b_in_ready) begin
        sb3.push_back(b_in_data);
        sent++;
      end
      if (b_out_valid && b_out_ready) begin
        chk("rnd_held", sb3.size() > 0, 1);
        exp_d = (sb3.size() > 0) ? sb3.pop_front() : 32'hX;
        chk("rnd_data", b_out_data, exp_d);
        recv++;
      end
      pov = b_out_valid; por = b_out_ready; pod = b_out_data;
      step();
      cyc++;
    end
    b_in_valid = 0;
    chk("rnd_count", recv, 10000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
